sync_req_arbiter: RTL and testbench

Round-robin front end for the synchronization-register unit. It collects atomic/sync requests from up to NUM_REQ requesters over valid/ready channels and issues them one at a time on the unit's unhandshaked request bus. It captures the unit's read data in the issue cycle and returns it as a single response tagged with the requester ID. Because only one request is in flight at a time, the read-modify-write ops in the sync unit are serialized.

---
 rtl/sync_req_arbiter.sv | 118 +++++++++++
 tb/tb_sync_req_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_req_arbiter.sv
// Round-robin front end for the synchronization-register unit: grants one
// requester at a time, issues it for one cycle and returns the pre-update data.
module sync_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 512
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0][35:0]         req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0][2:0]          req_type,
   output logic                             sync_valid,
   output logic [35:0]                      sync_addr,
   output logic [DATA_W-1:0]                sync_data,
   output logic [3:0]                       sync_id,
   output logic [2:0]                       sync_type,
   input  logic [DATA_W-1:0]                sync_rdata,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [3:0]                       rsp_id,
   output logic [2:0]                       rsp_type,
   output logic [31:0]                      rsp_data
);

   localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned ADDR_W = 36;
   localparam int unsigned TYPE_W = 3;

   typedef enum logic [1:0] {ARB, ISSUE, RESP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    hold_id;
   logic [ADDR_W-1:0]   hold_addr;
   logic [DATA_W-1:0]   hold_data;
   logic [TYPE_W-1:0]   hold_type;
   logic                grant_ok;
   logic [IDX_W-1:0]    grant_idx;
   int unsigned         cand;
   logic                unused_rdata;

   assign unused_rdata = ^sync_rdata[DATA_W-1:32];

   // First valid requester at or above ptr, wrapping modulo NUM_REQ.
   always_comb begin
      grant_ok  = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_ok && req_valid[IDX_W'(cand)]) begin
            grant_ok  = 1'b1;
            grant_idx = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      case (state_q)
         ARB: begin
            if (grant_ok && !rst) begin
               req_ready[grant_idx] = 1'b1;
               state_d              = ISSUE;
            end
         end
         ISSUE:   state_d = RESP;
         RESP:    if (rsp_ready) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ARB;
      else     state_q <= state_d;
   end

   // Holding register, rotating pointer and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q     <= '0;
         hold_id   <= '0;
         hold_addr <= '0;
         hold_data <= '0;
         hold_type <= '0;
         rsp_id    <= '0;
         rsp_type  <= '0;
         rsp_data  <= '0;
      end else begin
         if (state_q == ARB && grant_ok) begin
            hold_id   <= grant_idx;
            hold_addr <= req_addr[grant_idx];
            hold_data <= req_data[grant_idx];
            hold_type <= req_type[grant_idx];
            ptr_q     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
         end
         if (state_q == ISSUE) begin
            rsp_data <= sync_rdata[31:0];
            rsp_id   <= ID_W'(hold_id);
            rsp_type <= (hold_type == 3'b010) ? 3'b101 : 3'b110;
         end
      end
   end

   // The sync bus carries the held request only during ISSUE, zeros otherwise.
   assign sync_valid = (state_q == ISSUE);
   assign sync_addr  = sync_valid ? hold_addr : '0;
   assign sync_data  = sync_valid ? hold_data : '0;
   assign sync_id    = sync_valid ? ID_W'(hold_id) : '0;
   assign sync_type  = sync_valid ? hold_type : '0;
   assign rsp_valid  = (state_q == RESP);

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed bench for sync_req_arbiter with a small sync-unit memory model:
// type 3'b001 adds data[46:32], every other type writes data[31:0].
module tb_sync_req_arbiter;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DATA_W  = 512;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [NUM_REQ-1:0]              req_valid, req_ready;
   logic [NUM_REQ-1:0][35:0]        req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0][2:0]         req_type;
   logic                            sync_valid;
   logic [35:0]                     sync_addr;
   logic [DATA_W-1:0]               sync_data, sync_rdata;
   logic [3:0]                      sync_id;
   logic [2:0]                      sync_type;
   logic                            rsp_valid, rsp_ready;
   logic [3:0]                      rsp_id;
   logic [2:0]                      rsp_type;
   logic [31:0]                     rsp_data;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [16];
   logic        pre_en;
   logic [3:0]  pre_idx;
   logic [31:0] pre_val;

   sync_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
      .sync_valid(sync_valid), .sync_addr(sync_addr), .sync_data(sync_data),
      .sync_id(sync_id), .sync_type(sync_type), .sync_rdata(sync_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_type(rsp_type), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   // Sync unit model: read is combinational on sync_addr, update at the edge.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      end else if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end else if (sync_valid) begin
         if (sync_type == 3'b001) mem[sync_addr[5:2]] <= mem[sync_addr[5:2]] + 32'(sync_data[46:32]);
         else                     mem[sync_addr[5:2]] <= sync_data[31:0];
      end
   end

   always_comb sync_rdata = {{(DATA_W-32){1'b0}}, mem[sync_addr[5:2]]};

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'b0101; rsp_ready = 1'b0; pre_en = 1'b0;
      pre_idx = '0; pre_val = '0; req_addr = '0; req_data = '0; req_type = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      end
      checks++;
      if ({sync_valid, sync_addr, sync_id, sync_type, sync_data} !== '0) begin
         failures++; $display("FAIL reset_sync: got valid=%b addr=%h id=%h want all 0", sync_valid, sync_addr, sync_id);
      end
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== 40'h0) begin
         failures++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_type, rsp_data});
      end
      @(negedge clk);
      rst = 1'b0; req_valid = '0;
   endtask

   task automatic test_round_robin();
      int exp_g [5] = '{0, 1, 2, 3, 0};
      logic [31:0] exp_d;
      for (int i = 0; i < 4; i++) begin
         req_addr[i] = 36'h10 + 36'(4 * i);
         req_data[i] = DATA_W'(32'hA0 + 32'(i));
         req_type[i] = 3'b000;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         exp_d = (k < 4) ? 32'h1000_0004 + 32'(k) : 32'hA0;
         #1;
         checks++;
         if (req_ready !== 4'(1 << exp_g[k])) begin
            failures++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << exp_g[k]));
         end
         @(negedge clk); #1;
         checks++;
         if ({sync_valid, sync_id, req_ready} !== {1'b1, 4'(exp_g[k]), 4'b0}) begin
            failures++; $display("FAIL rr_issue%0d: got v=%b id=%0d rdy=%b want v=1 id=%0d rdy=0", k, sync_valid, sync_id, req_ready, exp_g[k]);
         end
         @(negedge clk); #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 4'(exp_g[k]), exp_d, 4'b0}) begin
            failures++; $display("FAIL rr_rsp%0d: got v=%b id=%0d data=%h rdy=%b want v=1 id=%0d data=%h rdy=0", k, rsp_valid, rsp_id, rsp_data, req_ready, exp_g[k], exp_d);
         end
         @(negedge clk);
         if (k == 4) req_valid = '0;
      end
   endtask

   task automatic test_single_op();
      @(negedge clk);
      req_addr[2] = 36'h4; req_data[2] = DATA_W'(32'h1234); req_type[2] = 3'b111;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++; $display("FAIL single_grant: got %b want 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if ({sync_valid, sync_id, sync_addr, sync_type, sync_data[31:0]} !== {1'b1, 4'd2, 36'h4, 3'b111, 32'h1234}) begin
         failures++; $display("FAIL single_issue: got v=%b id=%0d addr=%h type=%b data=%h want v=1 id=2 addr=4 type=111 data=1234", sync_valid, sync_id, sync_addr, sync_type, sync_data[31:0]);
      end
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== {1'b1, 4'd2, 3'b110, 32'h1000_0001}) begin
         failures++; $display("FAIL single_rsp: got v=%b id=%0d type=%b data=%h want v=1 id=2 type=110 data=10000001", rsp_valid, rsp_id, rsp_type, rsp_data);
      end
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, sync_valid, req_ready} !== 6'b0) begin
         failures++; $display("FAIL single_idle: got rsp_v=%b sync_v=%b rdy=%b want 0 0 0000", rsp_valid, sync_valid, req_ready);
      end
   endtask

   task automatic test_fetch_add();
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 4'd2; pre_val = 32'd10;
      @(negedge clk);
      pre_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_addr[i] = 36'h8;
         req_data[i] = DATA_W'(32'hFFFF);
         req_data[i][46:32] = 15'd5;
         req_type[i] = 3'b001;
      end
      req_valid = 4'b0011;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++; $display("FAIL fa_grant0: got %b want 0001", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0010;
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== {1'b1, 4'd0, 3'b110, 32'd10}) begin
         failures++; $display("FAIL fa_rsp0: got v=%b id=%0d type=%b data=%0d want v=1 id=0 type=110 data=10", rsp_valid, rsp_id, rsp_type, rsp_data);
      end
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++; $display("FAIL fa_grant1: got %b want 0010", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== {1'b1, 4'd1, 3'b110, 32'd15}) begin
         failures++; $display("FAIL fa_rsp1: got v=%b id=%0d type=%b data=%0d want v=1 id=1 type=110 data=15", rsp_valid, rsp_id, rsp_type, rsp_data);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      rsp_ready = 1'b0;
      req_addr[2] = 36'hC;  req_type[2] = 3'b010; req_data[2] = DATA_W'(32'h55);
      req_addr[3] = 36'h14; req_type[3] = 3'b100; req_data[3] = DATA_W'(32'h33);
      req_valid = 4'b1100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++; $display("FAIL bp_grant2: got %b want 0100", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b1000;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_type, rsp_data, req_ready, sync_valid} !== {1'b1, 4'd2, 3'b101, 32'h1000_0003, 4'b0, 1'b0}) begin
            failures++; $display("FAIL bp_stall%0d: got v=%b id=%0d type=%b data=%h rdy=%b sv=%b want v=1 id=2 type=101 data=10000003 rdy=0000 sv=0", k, rsp_valid, rsp_id, rsp_type, rsp_data, req_ready, sync_valid);
         end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, req_ready} !== 5'b1_0000) begin
         failures++; $display("FAIL bp_release: got v=%b rdy=%b want v=1 rdy=0000", rsp_valid, req_ready);
      end
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready} !== 5'b0_1000) begin
         failures++; $display("FAIL bp_grant3: got v=%b rdy=%b want v=0 rdy=1000", rsp_valid, req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== {1'b1, 4'd3, 3'b110, 32'hA1}) begin
         failures++; $display("FAIL bp_rsp3: got v=%b id=%0d type=%b data=%h want v=1 id=3 type=110 data=a1", rsp_valid, rsp_id, rsp_type, rsp_data);
      end
   endtask

   task automatic test_reset_in_issue();
      @(negedge clk);
      req_addr[1] = 36'h18; req_type[1] = 3'b111; req_data[1] = DATA_W'(32'h77);
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++; $display("FAIL ri_grant1: got %b want 0010", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b1001;
      #1;
      checks++;
      if ({sync_valid, sync_id, req_ready} !== {1'b1, 4'd1, 4'b0}) begin
         failures++; $display("FAIL ri_issue: got v=%b id=%0d rdy=%b want v=1 id=1 rdy=0000", sync_valid, sync_id, req_ready);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({req_ready, sync_valid, sync_addr, sync_data, sync_id, sync_type, rsp_valid, rsp_id, rsp_type, rsp_data} !== '0) begin
         failures++; $display("FAIL ri_async_clear: got rdy=%b sv=%b sid=%0d rv=%b rid=%0d rtype=%b rdata=%h want all 0", req_ready, sync_valid, sync_id, rsp_valid, rsp_id, rsp_type, rsp_data);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, req_ready} !== 5'b0_0001) begin
         failures++; $display("FAIL ri_ptr0: got v=%b rdy=%b want v=0 rdy=0001", rsp_valid, req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if ({sync_valid, sync_id, rsp_valid} !== {1'b1, 4'd0, 1'b0}) begin
         failures++; $display("FAIL ri_reissue: got sv=%b id=%0d rv=%b want sv=1 id=0 rv=0", sync_valid, sync_id, rsp_valid);
      end
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 4'd0, 32'h1000_0002}) begin
         failures++; $display("FAIL ri_rsp0: got v=%b id=%0d data=%h want v=1 id=0 data=10000002", rsp_valid, rsp_id, rsp_data);
      end
   endtask

   task automatic test_drop_before_grant();
      @(negedge clk);
      req_valid = 4'b0110;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++; $display("FAIL drop_grant1: got %b want 0010", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b1000;
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== {1'b1, 4'd1, 3'b110, 32'h1000_0006}) begin
         failures++; $display("FAIL drop_rsp1: got v=%b id=%0d type=%b data=%h want v=1 id=1 type=110 data=10000006", rsp_valid, rsp_id, rsp_type, rsp_data);
      end
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++; $display("FAIL drop_skip2: got %b want 1000", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_type, rsp_data} !== {1'b1, 4'd3, 3'b110, 32'h1000_0005}) begin
         failures++; $display("FAIL drop_rsp3: got v=%b id=%0d type=%b data=%h want v=1 id=3 type=110 data=10000005", rsp_valid, rsp_id, rsp_type, rsp_data);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single_op();
      test_fetch_add();
      test_backpressure();
      test_reset_in_issue();
      test_drop_before_grant();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
